fa_serial_ctrl: RTL and testbench



---
 rtl/fa_serial_ctrl_pkg.sv | 15 +
 rtl/fa_serial_ctrl_if.sv | 23 ++
 rtl/fa_serial_ctrl_full_adder.sv | 12 +
 rtl/fa_serial_ctrl.sv | 95 +++++++++
 tb/tb_fa_serial_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fa_serial_ctrl_pkg.sv
// Shared types for the bit-serial full-adder sequencer.
package fa_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fa_state_e;

   // Bit-index width; a 1-bit operand still needs a 1-bit index register.
   function automatic int idx_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fa_serial_ctrl_if.sv
// Request/result bundle between the bus side and the serial-add sequencer.
interface fa_serial_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum_out;
   logic             cout;

   modport master (
      output start, a_in, b_in, cin_in,
      input  busy, done, sum_out, cout
   );

   modport slave (
      input  start, a_in, b_in, cin_in,
      output busy, done, sum_out, cout
   );
endinterface

// File: rtl/fa_serial_ctrl_full_adder.sv
// One-bit combinational full-adder cell; outputs are held low while rst is high.
module full_adder (
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = !rst & (a ^ b ^ cin);
   assign cout = !rst & ((a & b) | (cin & (a ^ b)));
endmodule

// File: rtl/fa_serial_ctrl.sv
// Bit-serial add sequencer: walks one full_adder cell across WIDTH operand bits, LSB first.
//   state | meaning
//   IDLE  | waiting for start; last result held on sum_out/cout
//   RUN   | one operand bit per clock through u_fa, carry recirculated
//   DONE  | result valid, done pulsed; start here begins the next add
module fa_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   fa_serial_ctrl_if.slave    bus
);
   import fa_ctrl_pkg::*;

   localparam int            IW       = idx_width(WIDTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   fa_state_e        state;
   fa_state_e        state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             load;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (idx == IDX_LAST) state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
      load     = bus.start && ((state == IDLE) || (state == DONE));
      fa_a     = 1'b0;
      fa_b     = 1'b0;
      fa_cin   = 1'b0;
      // Mask-select rather than part-select so WIDTH=1 indexes cleanly.
      if (state == RUN) begin
         fa_a   = |(a_reg & (WIDTH'(1) << idx));
         fa_b   = |(b_reg & (WIDTH'(1) << idx));
         fa_cin = carry_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (load) begin
         idx       <= '0;
         a_reg     <= bus.a_in;
         b_reg     <= bus.b_in;
         sum_reg   <= '0;
         carry_reg <= bus.cin_in;
      end else if (state == RUN) begin
         // sum_reg was cleared on load, so OR-ing in each bit is sufficient.
         sum_reg   <= sum_reg | (WIDTH'(fa_sum) << idx);
         carry_reg <= fa_cout;
         if (idx != IDX_LAST) idx <= idx + IW'(1);
      end
   end

   assign bus.sum_out = sum_reg;
   assign bus.cout    = carry_reg;

   full_adder u_fa (
      .rst  (!rst),
      .a    (fa_a),
      .b    (fa_b),
      .cin  (fa_cin),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed and random checks of fa_serial_ctrl at WIDTH=8 and WIDTH=1.
module tb_fa_serial_ctrl;

   logic clk;
   logic rst;

   int compares = 0;
   int fails    = 0;

   int         lat;
   int         bcnt;
   int         stray;
   logic [7:0] s;
   logic       co;
   logic [7:0] ra;
   logic [7:0] rb;
   logic       rc;
   logic [8:0] rexp;

   fa_serial_ctrl_if #(.WIDTH(8)) b8 ();
   fa_serial_ctrl_if #(.WIDTH(1)) b1 ();

   fa_serial_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   fa_serial_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compares++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts an add on the 8-bit instance and waits (bounded) for done.
   // repulse_k > 0 raises start with zero operands during that RUN cycle.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int repulse_k, output int lat_o, output int bcnt_o,
                         output logic [7:0] s_o, output logic co_o);
      lat_o  = 0;
      bcnt_o = 0;
      s_o    = '0;
      co_o   = 1'b0;
      b8.start  = 1'b1;
      b8.a_in   = a;
      b8.b_in   = b;
      b8.cin_in = c;
      for (int k = 1; k <= 40; k++) begin
         tick();
         b8.start = (k == repulse_k);
         if (k == repulse_k) begin
            b8.a_in   = 8'h00;
            b8.b_in   = 8'h00;
            b8.cin_in = 1'b0;
         end
         if (b8.busy) bcnt_o++;
         if (b8.done) begin
            lat_o = k;
            s_o   = b8.sum_out;
            co_o  = b8.cout;
            break;
         end
      end
      b8.start = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      b8.start  = 1'b0;
      b8.a_in   = '0;
      b8.b_in   = '0;
      b8.cin_in = 1'b0;
      b1.start  = 1'b0;
      b1.a_in   = '0;
      b1.b_in   = '0;
      b1.cin_in = 1'b0;
      repeat (3) tick();

      chk("rst_busy",  b8.busy,    0);
      chk("rst_done",  b8.done,    0);
      chk("rst_sum",   b8.sum_out, 0);
      chk("rst_cout",  b8.cout,    0);
      chk("rst_done1", b1.done,    0);
      chk("rst_sum1",  b1.sum_out, 0);
      rst = 1'b1;
      tick();

      // FF + 01 + 0 = 0x100
      run_op(8'hFF, 8'h01, 1'b0, 0, lat, bcnt, s, co);
      chk("ff01_lat",  lat,  9);
      chk("ff01_busy", bcnt, 8);
      chk("ff01_sum",  s,    8'h00);
      chk("ff01_cout", co,   1);
      tick();
      chk("ff01_done_pulse", b8.done,    0);
      chk("ff01_hold_sum",   b8.sum_out, 8'h00);
      chk("ff01_hold_cout",  b8.cout,    1);

      // 5A + 3C + 1 = 0x97
      run_op(8'h5A, 8'h3C, 1'b1, 0, lat, bcnt, s, co);
      chk("5a3c_lat",  lat,  9);
      chk("5a3c_busy", bcnt, 8);
      chk("5a3c_sum",  s,    8'h97);
      chk("5a3c_cout", co,   0);
      tick();

      // start re-pulsed mid-RUN with zero operands must be ignored
      run_op(8'h5A, 8'h3C, 1'b1, 3, lat, bcnt, s, co);
      chk("repulse_lat",  lat, 9);
      chk("repulse_sum",  s,   8'h97);
      chk("repulse_cout", co,  0);
      tick();

      // reset while bit 3 is in flight
      b8.start  = 1'b1;
      b8.a_in   = 8'hAA;
      b8.b_in   = 8'h55;
      b8.cin_in = 1'b1;
      tick();
      b8.start = 1'b0;
      repeat (3) tick();
      chk("midrun_busy", b8.busy, 1);
      rst = 1'b0;
      tick();
      chk("midrst_busy", b8.busy,    0);
      chk("midrst_done", b8.done,    0);
      chk("midrst_sum",  b8.sum_out, 0);
      chk("midrst_cout", b8.cout,    0);
      tick();
      chk("midrst_done2", b8.done, 0);
      rst   = 1'b1;
      stray = 0;
      repeat (12) begin
         tick();
         if (b8.done || b8.busy) stray++;
      end
      chk("midrst_stray", stray, 0);
      run_op(8'h01, 8'h01, 1'b0, 0, lat, bcnt, s, co);
      chk("post_rst_lat",  lat, 9);
      chk("post_rst_sum",  s,   8'h02);
      chk("post_rst_cout", co,  0);
      tick();

      // back-to-back: second start asserted in the first op's DONE cycle
      run_op(8'hFF, 8'h01, 1'b0, 0, lat, bcnt, s, co);
      chk("b2b_first_lat",  lat, 9);
      chk("b2b_first_sum",  s,   8'h00);
      chk("b2b_first_cout", co,  1);
      run_op(8'h80, 8'h80, 1'b0, 0, lat, bcnt, s, co);
      chk("b2b_second_lat",  lat,  9);
      chk("b2b_second_busy", bcnt, 8);
      chk("b2b_second_sum",  s,    8'h00);
      chk("b2b_second_cout", co,   1);
      tick();

      // WIDTH=1: 1 + 1 + 1 = 0b11
      b1.start  = 1'b1;
      b1.a_in   = 1'b1;
      b1.b_in   = 1'b1;
      b1.cin_in = 1'b1;
      tick();
      b1.start = 1'b0;
      chk("w1_busy",    b1.busy, 1);
      chk("w1_nodone",  b1.done, 0);
      tick();
      chk("w1_done",    b1.done,    1);
      chk("w1_sum",     b1.sum_out, 1);
      chk("w1_cout",    b1.cout,    1);
      tick();
      chk("w1_idle_done", b1.done, 0);

      for (int n = 0; n < 1000; n++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rc   = 1'($urandom_range(0, 1));
         rexp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         run_op(ra, rb, rc, 0, lat, bcnt, s, co);
         chk("rand_result", {co, s}, rexp);
         chk("rand_lat",    lat,     9);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
